ram_sdp_param: RTL and testbench

- Parametrised simple-dual-port synchronous RAM: one write port, one read port, shared clock.
- Generalises the fixed 32x32 RAM with:
  - configurable width and depth
  - per-byte write enables
  - a read-valid strobe
  - a selectable read/write collision mode
  - a self-clearing initialisation sweep after reset
- Used as the generic storage primitive for buffers and register files across the design.

---
 rtl/ram_pkg.sv | 30 +++
 rtl/ram_init_sweep.sv | 55 +++++
 rtl/ram_sdp_param.sv | 98 +++++++++
 tb/tb_ram_sdp_param.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised simple-dual-port RAM.
// Collision-mode constants, sweep FSM state encoding and the byte-merge helper.
package ram_pkg;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int MERGE_W  = 1024;
  localparam int MERGE_BE = MERGE_W / 8;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } sweep_state_t;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]  old_word,
    input logic [MERGE_W-1:0]  new_word,
    input logic [MERGE_BE-1:0] be
  );
    logic [MERGE_W-1:0] merged;
    merged = old_word;
    for (int k = 0; k < MERGE_BE; k++) begin
      if (be[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ram_init_sweep.sv
// Post-reset clear sweep: walks every address once, writing zero, then idles.
// state | meaning
// INIT  | clearing address sweep_addr this cycle; port requests blocked
// READY | sweep complete; RAM ports serve traffic
module ram_init_sweep
  import ram_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              sweep_we,
  output logic              init_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  sweep_state_t      state;
  logic [ADDR_W-1:0] sweep_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      sweep_cnt <= '0;
      sweep_we  <= 1'b1;
      init_busy <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_ADDR) begin
            state     <= READY;
            sweep_we  <= 1'b0;
            init_busy <= 1'b0;
          end
        end
        READY: begin
          sweep_cnt <= '0;
          sweep_we  <= 1'b0;
          init_busy <= 1'b0;
        end
        default: begin
          state     <= INIT;
          sweep_cnt <= '0;
          sweep_we  <= 1'b1;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  assign sweep_addr = sweep_cnt;

endmodule

// File: rtl/ram_sdp_param.sv
// Parametrised simple-dual-port RAM with byte enables, read-valid and clear sweep.
// Define RAM_OUT_REG_EN to add a second output register stage (read latency 2).
module ram_sdp_param
  import ram_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int RD_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                init_busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_we;
  logic              port_wr;
  logic              port_rd;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] rd_word;

  ram_init_sweep #(
    .ADDR_W(ADDR_W)
  ) u_sweep (
    .clk       (clk),
    .rst       (rst),
    .sweep_addr(sweep_addr),
    .sweep_we  (sweep_we),
    .init_busy (init_busy)
  );

  assign port_wr = wr_en & ~init_busy;
  assign port_rd = rd_en & ~init_busy;

  assign old_word    = mem[wr_addr];
  assign merged_word = DATA_W'(byte_merge(MERGE_W'(old_word), MERGE_W'(wr_data),
                                          MERGE_BE'(wr_be)));

  // Write-first forwards the merged word so partial writes still return old bytes.
  always_comb begin
    rd_word = mem[rd_addr];
    if ((RD_MODE == WR_FIRST) && port_wr && (wr_addr == rd_addr)) begin
      rd_word = merged_word;
    end
  end

  // Array is deliberately not reset; the sweep owns the write port while busy.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= '0;
    end else if (port_wr) begin
      mem[wr_addr] <= merged_word;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      s1_valid <= port_rd;
      if (port_rd) s1_data <= rd_word;
      rd_valid <= s1_valid;
      if (s1_valid) rd_data <= s1_data;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= port_rd;
      if (port_rd) rd_data <= rd_word;
    end
  end
`endif

endmodule

// File: tb/tb_ram_sdp_param.sv
// Directed bench for ram_sdp_param: one read-first and one write-first instance
// share the same stimulus; honours RAM_OUT_REG_EN for the read latency.
module tb_ram_sdp_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr = '0;
  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic        busy0, busy1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_sdp_param #(.DATA_W(32), .ADDR_W(5), .RD_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .init_busy(busy0)
  );

  ram_sdp_param #(.DATA_W(32), .ADDR_W(5), .RD_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .init_busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  // Read ra (optionally with a same-cycle write); e0/e1 are read-first/write-first results.
  task automatic rdw(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [3:0] be, input logic [4:0] ra,
                     input logic [31:0] e0, input logic [31:0] e1, input string tag);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = 1'b1; rd_addr = ra;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
`ifdef RAM_OUT_REG_EN
    chk({tag, "_lat"}, {30'd0, rd_valid0, rd_valid1}, 32'd0);
    tick();
`endif
    chk({tag, "_valid"}, {30'd0, rd_valid0, rd_valid1}, 32'd3);
    chk({tag, "_data0"}, rd_data0, e0);
    chk({tag, "_data1"}, rd_data1, e1);
    tick();
    chk({tag, "_drop"}, {30'd0, rd_valid0, rd_valid1}, 32'd0);
    chk({tag, "_hold"}, rd_data0, e0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e, input string tag);
    rdw(1'b0, 5'd0, 32'd0, 4'd0, a, e, e, tag);
  endtask

  // Counts cycles until both instances leave INIT; optional port requests ride along.
  task automatic sweep_wait(input bit poke, output int n, output int viol);
    n = 0; viol = 0;
    if (poke) begin
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h1234_5678; wr_be = 4'hF;
      rd_en = 1'b1; rd_addr = 5'd2;
    end
    while ((busy0 || busy1) && n < 100) begin
      tick();
      n++;
      if (rd_valid0 || rd_valid1 || rd_data0 != 0 || rd_data1 != 0) viol++;
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, viol;
    repeat (3) tick();
    chk("reset_outs", {rd_data0 | rd_data1, 28'd0, rd_valid0, rd_valid1, busy0, busy1} >> 0,
        {32'd0 | 32'd0} | 32'd3);
    rst = 1'b1;
    #1;
    chk("busy_at_release", {30'd0, busy0, busy1}, 32'd3);

    sweep_wait(1'b1, n, viol);
    chk("init_cycles", n, 32);
    chk("init_no_valid", viol, 0);
    rd(5'd7, 32'h0, "rd7_zero");
    rd(5'd2, 32'h0, "rd2_init_wr_ignored");
    rd(5'd31, 32'h0, "rd31_zero");

    wr(5'd3, 32'hDEAD_BEEF, 4'hF);
    rd(5'd3, 32'hDEAD_BEEF, "rd3_full");
    wr(5'd3, 32'h1122_3344, 4'b0101);
    rd(5'd3, 32'hDE22_BE44, "rd3_be0101");
    wr(5'd3, 32'hFFFF_FFFF, 4'b0000);
    rd(5'd3, 32'hDE22_BE44, "rd3_be0");

    wr(5'd5, 32'hAAAA_AAAA, 4'hF);
    rdw(1'b1, 5'd5, 32'h5555_5555, 4'hF, 5'd5, 32'hAAAA_AAAA, 32'h5555_5555, "coll5");
    rd(5'd5, 32'h5555_5555, "rd5_after_coll");

    wr(5'd6, 32'h1111_1111, 4'hF);
    rdw(1'b1, 5'd6, 32'hFFFF_FFFF, 4'b0011, 5'd6, 32'h1111_1111, 32'h1111_FFFF, "coll6_part");
    rd(5'd6, 32'h1111_FFFF, "rd6_after_coll");

    rdw(1'b1, 5'd31, 32'hCAFE_F00D, 4'hF, 5'd5, 32'h5555_5555, 32'h5555_5555, "indep");
    rd(5'd31, 32'hCAFE_F00D, "rd31_top");

    wr(5'd1, 32'h1, 4'hF);
    wr(5'd2, 32'h2, 4'hF);
    wr(5'd3, 32'h3, 4'hF);
    rd_en = 1'b1; rd_addr = 5'd1;
    tick();
`ifdef RAM_OUT_REG_EN
    chk("stream_lat", {30'd0, rd_valid0, rd_valid1}, 32'd0);
    rd_addr = 5'd2;
    tick();
    chk("stream_d1", {rd_data0[30:0], rd_valid0}, {31'h1, 1'b1});
    rd_addr = 5'd3;
    tick();
    rd_en = 1'b0;
    chk("stream_d2", {rd_data0[30:0], rd_valid0}, {31'h2, 1'b1});
    tick();
`else
    chk("stream_d1", {rd_data0[30:0], rd_valid0}, {31'h1, 1'b1});
    rd_addr = 5'd2;
    tick();
    chk("stream_d2", {rd_data0[30:0], rd_valid0}, {31'h2, 1'b1});
    rd_addr = 5'd3;
    tick();
    rd_en = 1'b0;
`endif
    chk("stream_d3", {rd_data1[30:0], rd_valid1}, {31'h3, 1'b1});
    tick();
    chk("stream_end", {30'd0, rd_valid0, rd_valid1}, 32'd0);

    wr(5'd3, 32'h0BAD_F00D, 4'hF);
    rd(5'd3, 32'h0BAD_F00D, "rd3_pre_rst");
    rst = 1'b0;
    #1;
    chk("rst_ready_data", rd_data0 | rd_data1, 32'h0);
    chk("rst_ready_flags", {30'd0, rd_valid0 | rd_valid1, busy0 & busy1}, 32'd1);
    repeat (2) tick();
    rst = 1'b1;
    sweep_wait(1'b0, n, viol);
    chk("resweep_cycles", n, 32);
    rd(5'd3, 32'h0, "rd3_after_rst");
    rd(5'd6, 32'h0, "rd6_after_rst");

    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (10) tick();
    chk("mid_sweep_busy", {30'd0, busy0, busy1}, 32'd3);
    rst = 1'b0;
    #1;
    chk("mid_rst_outs", {rd_data0 | rd_data1, 31'd0, rd_valid0 | rd_valid1} >> 0, 32'd0);
    tick();
    rst = 1'b1;
    sweep_wait(1'b0, n, viol);
    chk("mid_resweep_cycles", n, 32);
    rd(5'd10, 32'h0, "rd10_after_mid_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
